// File: rtl/starflux_pkg.sv
// rtl/starflux_pkg.sv - shared Starflux playfield constants, column direction type and grid index helper
//
// Purpose : defaults for the projectile grid geometry and the flat-bus index
//           mapping shared by the projectile field and the VGA renderer.
// Contents: DEF_GRID_W / DEF_GRID_H / DEF_XW, dir_e, grid_idx(col, row).

package starflux_pkg;

    localparam int DEF_GRID_W = 160;
    localparam int DEF_GRID_H = 120;
    localparam int DEF_XW     = 8;

    // DIR_UP moves bits toward row 0, DIR_DOWN toward row GRID_H-1.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Flat bit position of cell (col, row): each column is a contiguous
    // GRID_H-bit slice with row 0 at the least significant end.
    function automatic int grid_idx(input int col, input int row, input int grid_h = DEF_GRID_H);
        return grid_h * col + row;
    endfunction

endpackage

// File: rtl/projectile_column.sv
// rtl/projectile_column.sv - one GRID_H-bit shot column shifting one row per tick
//
// Purpose : holds the shots of a single column of one plane. On tick the
//           column shifts one row in direction DIR, the inject bit enters at
//           the entry row, and any row set in kill is cleared.
// Ports   : clock, reset (sync, active-high), tick (advance strobe),
//           inject (new shot at entry row), kill (post-shift clear mask),
//           col_q (column contents, bit = row), exit_bit (bit leaving on tick).

module projectile_column
    import starflux_pkg::*;
#(
    parameter int   GRID_H = DEF_GRID_H,
    parameter dir_e DIR    = DIR_UP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              inject,
    input  logic [GRID_H-1:0] kill,
    output logic [GRID_H-1:0] col_q,
    output logic              exit_bit
);

    logic [GRID_H-1:0] col_d;

    always_comb begin
        col_d = col_q;
        if (tick) begin
            if (DIR == DIR_UP) begin
                // Row r takes row r+1; the entry row is the bottom one.
                col_d = {inject, col_q[GRID_H-1:1]} & ~kill;
            end else begin
                // Row r takes row r-1; the entry row is the top one.
                col_d = {col_q[GRID_H-2:0], inject} & ~kill;
            end
        end
    end

    // The bit that falls off the end on the next tick, taken before the
    // shift so a hit is reported even if the cell is re-used by an inject.
    assign exit_bit = (DIR == DIR_UP) ? col_q[0] : col_q[GRID_H-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/projectile_grid.sv
// rtl/projectile_grid.sv - two-plane projectile field with fire rate limit, annihilation and hit reporting
//
// Purpose : player shots travel up, enemy shots travel down, one row per tick.
//           Handles shoot edge detection, the player fire cooldown, mutual
//           annihilation of colliding shots and exit-row hit detection.
// Ports   : clock, reset (sync, active-high), tick, shoot (raw level),
//           enemy_fire (sampled on tick), user_x, enemy_x (columns),
//           player_grid / enemy_grid (bit GRID_H*col+row), hit_enemy,
//           hit_player (one-cycle pulses), cooldown_busy.

module projectile_grid
    import starflux_pkg::*;
#(
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int XW       = DEF_XW,
    parameter int COOLDOWN = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       shoot,
    input  logic                       enemy_fire,
    input  logic [XW-1:0]              user_x,
    input  logic [XW-1:0]              enemy_x,
    output logic [GRID_W*GRID_H-1:0]   player_grid,
    output logic [GRID_W*GRID_H-1:0]   enemy_grid,
    output logic                       hit_enemy,
    output logic                       hit_player,
    output logic                       cooldown_busy
);

    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic          shoot_q;
    logic          pending_q, pending_d;
    logic [CW-1:0] cd_q, cd_d;
    logic          hit_enemy_q, hit_enemy_d;
    logic          hit_player_q, hit_player_d;

    logic          shoot_edge;
    logic          user_ok;
    logic          fire;

    logic [GRID_W-1:0] p_inj, e_inj;
    logic [GRID_W-1:0] p_exit, e_exit;
    logic [GRID_H-1:0] p_col [GRID_W];
    logic [GRID_H-1:0] e_col [GRID_W];
    logic [GRID_H-1:0] kill  [GRID_W];

    always_comb begin
        shoot_edge = shoot & ~shoot_q;
        user_ok    = int'(user_x) < GRID_W;
        fire       = tick & pending_q & (cd_q == '0) & user_ok;

        // A tick always consumes the pending request; an edge arriving on
        // the tick cycle itself survives to the following tick.
        pending_d = shoot_edge | (pending_q & ~tick);

        cd_d = cd_q;
        if (fire) begin
            cd_d = CW'(COOLDOWN);
        end else if (tick && (cd_q != '0)) begin
            cd_d = cd_q - CW'(1);
        end

        hit_enemy_d  = 1'b0;
        hit_player_d = 1'b0;
        for (int c = 0; c < GRID_W; c++) begin
            // Out-of-range x never matches a column, so it neither injects
            // nor scores a hit.
            p_inj[c] = fire & (int'(user_x) == c);
            e_inj[c] = tick & enemy_fire & (int'(enemy_x) == c);

            // Collision mask is the overlap of the two planes' post-shift,
            // post-inject contents; each column clears it from its plane.
            kill[c] = {p_inj[c], p_col[c][GRID_H-1:1]} &
                      {e_col[c][GRID_H-2:0], e_inj[c]};

            if (tick && p_exit[c] && (int'(enemy_x) == c)) begin
                hit_enemy_d = 1'b1;
            end
            if (tick && e_exit[c] && (int'(user_x) == c)) begin
                hit_player_d = 1'b1;
            end
        end
    end

    for (genvar c = 0; c < GRID_W; c++) begin : g_col
        projectile_column #(
            .GRID_H (GRID_H),
            .DIR    (DIR_UP)
        ) u_player (
            .clock    (clock),
            .reset    (reset),
            .tick     (tick),
            .inject   (p_inj[c]),
            .kill     (kill[c]),
            .col_q    (p_col[c]),
            .exit_bit (p_exit[c])
        );

        projectile_column #(
            .GRID_H (GRID_H),
            .DIR    (DIR_DOWN)
        ) u_enemy (
            .clock    (clock),
            .reset    (reset),
            .tick     (tick),
            .inject   (e_inj[c]),
            .kill     (kill[c]),
            .col_q    (e_col[c]),
            .exit_bit (e_exit[c])
        );

        assign player_grid[grid_idx(c, 0, GRID_H) +: GRID_H] = p_col[c];
        assign enemy_grid[grid_idx(c, 0, GRID_H) +: GRID_H]  = e_col[c];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shoot_q      <= 1'b0;
            pending_q    <= 1'b0;
            cd_q         <= '0;
            hit_enemy_q  <= 1'b0;
            hit_player_q <= 1'b0;
        end else begin
            shoot_q      <= shoot;
            pending_q    <= pending_d;
            cd_q         <= cd_d;
            hit_enemy_q  <= hit_enemy_d;
            hit_player_q <= hit_player_d;
        end
    end

    assign hit_enemy     = hit_enemy_q;
    assign hit_player    = hit_player_q;
    assign cooldown_busy = (cd_q != '0);

endmodule
